// File: rtl/data_mem_arbiter_pkg.sv
// data_mem_arbiter_pkg
//   Shared types for the data memory arbiter: who drives the memory port
//   in the current cycle.
package data_mem_arbiter_pkg;

  typedef enum logic [1:0] {
    OWNER_NONE = 2'd0,
    OWNER_CORE = 2'd1,
    OWNER_HOST = 2'd2
  } owner_e;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// data_mem_arbiter_if
//   Bundles the three buses around the arbiter:
//     core_*  : execute-stage data port of the pipelined core
//     host_*  : host/loader port (preload, debug readout, DMA)
//     mem_*   : single-port synchronous data memory
//   slave  - arbiter view (consumes core/host requests, drives the memory)
//   master - environment view (core, host and memory model)
interface data_mem_arbiter_if #(
  parameter int D_SIZE = 32,
  parameter int A_SIZE = 10
);
  logic              core_read;
  logic              core_write;
  logic [A_SIZE-1:0] core_address;
  logic [D_SIZE-1:0] core_data_out;
  logic [D_SIZE-1:0] core_data_in;
  logic              core_wait;

  logic              host_req;
  logic              host_we;
  logic [A_SIZE-1:0] host_addr;
  logic [D_SIZE-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [D_SIZE-1:0] host_rdata;

  logic              mem_read;
  logic              mem_write;
  logic [A_SIZE-1:0] mem_address;
  logic [D_SIZE-1:0] mem_data_out;
  logic [D_SIZE-1:0] mem_data_in;

  modport slave (
    input  core_read, core_write, core_address, core_data_out,
    input  host_req, host_we, host_addr, host_wdata,
    input  mem_data_in,
    output core_data_in, core_wait,
    output host_gnt, host_rvalid, host_rdata,
    output mem_read, mem_write, mem_address, mem_data_out
  );

  modport master (
    output core_read, core_write, core_address, core_data_out,
    output host_req, host_we, host_addr, host_wdata,
    output mem_data_in,
    input  core_data_in, core_wait,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_read, mem_write, mem_address, mem_data_out
  );

endinterface

// File: rtl/data_mem_arbiter_starve_counter.sv
// starve_counter
//   Counts consecutive cycles in which the host is requesting but not
//   granted. Saturates at STARVE_LIMIT; at_limit tells the grant logic to
//   force a host slot.
//   Ports: clk, rst_n (async, active low), req (host request),
//          gnt (host granted this cycle), at_limit (count == STARVE_LIMIT).
module starve_counter #(
  parameter int STARVE_LIMIT = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req,
  input  logic gnt,
  output logic at_limit
);

  localparam int            CW    = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_d, cnt_q;

  always_comb begin
    cnt_d = cnt_q;
    if (!req || gnt)          cnt_d = '0;
    else if (cnt_q != LIMIT)  cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign at_limit = (cnt_q == LIMIT);

endmodule

// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter
//   Shares the single-port data memory between the core's execute-stage
//   data port and the host port. The core owns the memory by default; the
//   host takes idle cycles, and after STARVE_LIMIT denied cycles gets one
//   forced slot during which core_wait stalls the core.
//   Ports: clk, rst_n (async, active low), bus (data_mem_arbiter_if.slave:
//          core_*, host_*, mem_* groups).
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int D_SIZE       = 32,
  parameter int A_SIZE       = 10,
  parameter int STARVE_LIMIT = 8
) (
  input logic                clk,
  input logic                rst_n,
  data_mem_arbiter_if.slave  bus
);

  owner_e            owner;
  logic              core_acc, at_limit, forced, host_gnt;
  logic              mem_read, mem_write;
  logic [A_SIZE-1:0] mem_address;
  logic [D_SIZE-1:0] mem_data_out;
  logic              host_rvalid_d, host_rvalid_q;

  assign core_acc = bus.core_read | bus.core_write;
  assign forced   = at_limit & bus.host_req;

  starve_counter #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (bus.host_req),
    .gnt      (host_gnt),
    .at_limit (at_limit)
  );

  always_comb begin
    owner = OWNER_NONE;
    if (forced)            owner = OWNER_HOST;
    else if (core_acc)     owner = OWNER_CORE;
    else if (bus.host_req) owner = OWNER_HOST;
  end

  // Memory mux. A core write with a simultaneous read drops the read.
  always_comb begin
    mem_read     = 1'b0;
    mem_write    = 1'b0;
    mem_address  = '0;
    mem_data_out = '0;
    case (owner)
      OWNER_CORE: begin
        mem_write    = bus.core_write;
        mem_read     = bus.core_read & ~bus.core_write;
        mem_address  = bus.core_address;
        mem_data_out = bus.core_data_out;
      end
      OWNER_HOST: begin
        mem_write    = bus.host_we;
        mem_read     = ~bus.host_we;
        mem_address  = bus.host_addr;
        mem_data_out = bus.host_wdata;
      end
      default: ;
    endcase
  end

  assign host_gnt      = (owner == OWNER_HOST);
  assign host_rvalid_d = host_gnt & ~bus.host_we;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) host_rvalid_q <= 1'b0;
    else        host_rvalid_q <= host_rvalid_d;
  end

  assign bus.mem_read     = mem_read;
  assign bus.mem_write    = mem_write;
  assign bus.mem_address  = mem_address;
  assign bus.mem_data_out = mem_data_out;
  assign bus.host_gnt     = host_gnt;
  assign bus.host_rvalid  = host_rvalid_q;
  assign bus.host_rdata   = bus.mem_data_in;
  // Core samples this only one cycle after its own served read.
  assign bus.core_data_in = bus.mem_data_in;
  assign bus.core_wait    = forced & core_acc;

endmodule
